// File: rtl/mult8_seq_ctrl_pkg.sv
// mult8_pkg: shared encodings for the sequential 8x8 multiplier controller.
//   state_t  : FSM states, encoded exactly as exposed on state_out
//   SH0/4/8  : partial-product shift encodings
//   step_of  : per-step (sel, shift) lookup indexed by the CALC step counter
package mult8_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    CALC = 3'b001,
    DONE = 3'b010
  } state_t;

  localparam logic [1:0] SH0 = 2'b00;
  localparam logic [1:0] SH4 = 2'b01;
  localparam logic [1:0] SH8 = 2'b10;

  typedef struct packed {
    logic [1:0] sel;    // {A nibble, B nibble}, 1 = high nibble
    logic [1:0] shift;
  } step_t;

  // Nibble pair -> weight: lo*lo <<0, lo*hi and hi*lo <<4, hi*hi <<8.
  function automatic step_t step_of(input logic [1:0] cnt);
    step_t s;
    unique case (cnt)
      2'd0:    s = '{sel: 2'b00, shift: SH0};
      2'd1:    s = '{sel: 2'b01, shift: SH4};
      2'd2:    s = '{sel: 2'b10, shift: SH4};
      default: s = '{sel: 2'b11, shift: SH8};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mult8_seq_ctrl_if.sv
// mult8_seq_ctrl_if: handshake and datapath-control bundle of the multiplier
// controller.
//   master : system side, drives start/ack/abort, observes everything else
//   slave  : controller side, drives sel/shift/clr_acc/acc_en/busy/done/state_out
interface mult8_seq_ctrl_if;
  logic       start;
  logic       ack;
  logic       abort;
  logic [1:0] sel;
  logic [1:0] shift;
  logic       clr_acc;
  logic       acc_en;
  logic       busy;
  logic       done;
  logic [2:0] state_out;

  modport master (
    output start, ack, abort,
    input  sel, shift, clr_acc, acc_en, busy, done, state_out
  );

  modport slave (
    input  start, ack, abort,
    output sel, shift, clr_acc, acc_en, busy, done, state_out
  );
endinterface

// File: rtl/mult8_seq_ctrl_step_counter.sv
// step_counter: 2-bit CALC step counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (priority over en)
//   en         : increment enable
//   cnt        : current step
//   tc         : terminal count, cnt == 3
module step_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [1:0] cnt,
  output logic       tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= 2'd0;
    else if (clr) cnt <= 2'd0;
    else if (en)  cnt <= cnt + 2'd1;
  end

  assign tc = (cnt == 2'd3);

endmodule

// File: rtl/mult8_seq_ctrl.sv
// mult8_seq_ctrl: control FSM stepping a shared 4x4 multiplier through the
// four nibble-pair partial products of an 8x8 multiply.
//   clk, rst_n : clock, async active-low reset
//   bus.slave  : start/ack/abort in; sel, shift, clr_acc, acc_en, busy,
//                done, state_out out
// sel/shift/busy/done are registered alongside the state, so they are loaded
// with the values for the state/step being entered.
module mult8_seq_ctrl
  import mult8_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  mult8_seq_ctrl_if.slave bus
);

  state_t     state;
  logic [1:0] cnt;
  logic       tc;
  logic [1:0] sel_q, shift_q;
  logic       acc_en_q, busy_q, done_q;
  step_t      step0, nxt_step;

  // Counter only runs in CALC; held at 0 elsewhere so every entry starts at step 0.
  step_counter u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state != CALC) | bus.abort),
    .en    (state == CALC),
    .cnt   (cnt),
    .tc    (tc)
  );

  assign step0    = step_of(2'd0);
  assign nxt_step = step_of(cnt + 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_q    <= 2'b00;
      shift_q  <= SH0;
      acc_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= CALC;
            sel_q    <= step0.sel;
            shift_q  <= step0.shift;
            acc_en_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        CALC: begin
          if (bus.abort || tc) begin
            state    <= bus.abort ? IDLE : DONE;
            sel_q    <= 2'b00;
            shift_q  <= SH0;
            acc_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= !bus.abort;
          end else begin
            sel_q    <= nxt_step.sel;
            shift_q  <= nxt_step.shift;
          end
        end
        DONE: begin
          // start beats ack: restart straight into CALC with no IDLE gap
          if (bus.start) begin
            state    <= CALC;
            sel_q    <= step0.sel;
            shift_q  <= step0.shift;
            acc_en_q <= 1'b1;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end else if (bus.ack) begin
            state    <= IDLE;
            done_q   <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          sel_q    <= 2'b00;
          shift_q  <= SH0;
          acc_en_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  // Mealy clear: accumulator zeroes on the edge that accepts start. Gated by
  // rst_n so it also sits at 0 while reset is held.
  assign bus.clr_acc   = rst_n & bus.start & ((state == IDLE) | (state == DONE));
  // abort kills the add of the cycle it arrives in, not just the following ones.
  assign bus.acc_en    = acc_en_q & ~bus.abort;
  assign bus.sel       = sel_q;
  assign bus.shift     = shift_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_out = state;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
module tb_mult8_seq_ctrl;

  logic clk;
  logic rst_n;
  mult8_seq_ctrl_if bus ();

  mult8_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural datapath: nibble mux, 4x4 multiply, shifter, 16-bit accumulator.
  logic [7:0]  opa, opb;
  logic [15:0] acc;
  logic [3:0]  na, nb;
  logic [15:0] pp;
  always_comb begin
    na = bus.sel[1] ? opa[7:4] : opa[3:0];
    nb = bus.sel[0] ? opb[7:4] : opb[3:0];
    pp = 16'(na) * 16'(nb);
    case (bus.shift)
      2'b01:   pp = pp << 4;
      2'b10:   pp = pp << 8;
      default: pp = pp;
    endcase
  end
  always @(posedge clk) begin
    if (bus.clr_acc)     acc <= 16'h0;
    else if (bus.acc_en) acc <= acc + pp;
  end

  // Step table as written in the block description.
  logic [1:0] exp_shift [4];
  initial begin
    exp_shift[0] = 2'b00; exp_shift[1] = 2'b01;
    exp_shift[2] = 2'b01; exp_shift[3] = 2'b10;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge in IDLE or DONE: raise start, expect the Mealy clear.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit also_ack);
    opa = a; opb = b;
    bus.start = 1'b1;
    bus.ack   = also_ack;
    #1 chk("clr_acc_on_start", 32'(bus.clr_acc), 1);
    @(negedge clk);
    bus.ack = 1'b0;
  endtask

  // Walks the four CALC cycles. pulse_k: step at which start is re-raised;
  // abort_k: step at which abort is raised (-1 = none).
  task automatic calc(input logic [15:0] prod, input int pulse_k, input int abort_k,
                      output bit aborted);
    aborted = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("calc_state", 32'(bus.state_out), 32'h1);
      chk("calc_busy",  32'(bus.busy), 1);
      chk("calc_acc_en", 32'(bus.acc_en), 1);
      chk("calc_done",  32'(bus.done), 0);
      chk("calc_sel",   32'(bus.sel), k);
      chk("calc_shift", 32'(bus.shift), 32'(exp_shift[k]));
      bus.start = (k == pulse_k);
      if (k == pulse_k) #1 chk("calc_start_no_clr", 32'(bus.clr_acc), 0);
      if (k == abort_k) begin
        bus.abort = 1'b1;
        #1 chk("abort_acc_en_now", 32'(bus.acc_en), 0);
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abort_state", 32'(bus.state_out), 0);
        chk("abort_acc_en", 32'(bus.acc_en), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        aborted = 1'b1;
        return;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("done_high",  32'(bus.done), 1);
    chk("done_state", 32'(bus.state_out), 32'h2);
    chk("done_busy",  32'(bus.busy), 0);
    chk("done_sel",   32'({bus.sel, bus.shift}), 0);
    chk("product",    32'(acc), 32'(prod));
  endtask

  // Hold DONE for some cycles, then ack and expect IDLE.
  task automatic retire(input int hold, input logic [15:0] prod);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("done_hold", 32'(bus.done), 1);
      chk("done_hold_acc", 32'(acc), 32'(prod));
    end
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    chk("ack_idle", 32'(bus.state_out), 0);
    chk("ack_done_low", 32'(bus.done), 0);
  endtask

  task automatic quiet(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(name, 32'({bus.done, bus.busy, bus.state_out}), 0);
    end
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, 32'({bus.sel, bus.shift, bus.clr_acc, bus.acc_en, bus.busy,
                   bus.done, bus.state_out}), 0);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  initial begin
    vec_t vecs [6];
    bit   ab;
    logic [7:0] ra, rb;
    int   pk, akk;

    vecs[0] = '{8'hAB, 8'hCD, 16'h88EF};
    vecs[1] = '{8'h12, 8'h34, 16'h03A8};
    vecs[2] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[3] = '{8'h00, 8'h7F, 16'h0000};
    vecs[4] = '{8'h80, 8'h02, 16'h0100};
    vecs[5] = '{8'h0F, 8'hF0, 16'h0E10};

    bus.start = 1'b0; bus.ack = 1'b0; bus.abort = 1'b0;
    opa = 8'h0; opb = 8'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset_outs("reset_values");
    @(negedge clk);
    rst_n = 1'b1;
    quiet(2, "idle_after_reset");

    // Table vectors, each a full start/done/ack transaction.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, 1'b0);
      calc(vecs[i].prod, -1, -1, ab);
      retire(2, vecs[i].prod);
    end

    // Back-to-back via start held in DONE.
    issue(8'hFF, 8'hFF, 1'b0);
    calc(16'hFE01, -1, -1, ab);
    issue(8'h00, 8'h7F, 1'b0);
    calc(16'h0000, -1, -1, ab);
    retire(0, 16'h0000);

    // start re-pulsed at cnt=1 is ignored.
    issue(8'hAB, 8'hCD, 1'b0);
    calc(16'h88EF, 1, -1, ab);
    retire(0, 16'h88EF);
    quiet(3, "no_second_op");

    // abort at cnt=2, then a clean operation.
    issue(8'hAB, 8'hCD, 1'b0);
    calc(16'h88EF, -1, 2, ab);
    chk("aborted_flag", 32'(ab), 1);
    quiet(6, "after_abort");
    issue(8'h12, 8'h34, 1'b0);
    calc(16'h03A8, -1, -1, ab);
    retire(0, 16'h03A8);

    // Asynchronous reset mid-CALC.
    issue(8'hAB, 8'hCD, 1'b0);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("async_reset_outs");
    #1 rst_n = 1'b1;
    quiet(6, "after_reset_no_done");

    // start and ack together in DONE: restart wins.
    issue(8'h12, 8'h34, 1'b0);
    calc(16'h03A8, -1, -1, ab);
    issue(8'hAB, 8'hCD, 1'b1);
    chk("restart_state", 32'(bus.state_out), 32'h1);
    calc(16'h88EF, -1, -1, ab);
    retire(0, 16'h88EF);

    // Randomized operands, aborts and restart pulses against A*B.
    for (int it = 0; it < 30; it++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      akk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      pk  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : -1;
      issue(ra, rb, 1'b0);
      calc(16'(ra) * 16'(rb), pk, akk, ab);
      chk("rand_abort_match", 32'(ab), 32'(akk >= 0));
      if (!ab) retire(int'($urandom_range(0, 2)), 16'(ra) * 16'(rb));
      else     quiet(1, "rand_after_abort");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
